// File: rtl/lfsr_mask_pkg.sv
// Shared types, LFSR constants and the byte-replicating mask function
// for the LFSR keystream mask scheduler.
package lfsr_mask_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_WARM,
        ST_EMIT
    } state_e;

    localparam int LFSR_W = 20;
    localparam int TAP_A  = 15;
    localparam int TAP_B  = 11;
    localparam int TAP_C  = 7;
    localparam int TAP_D  = 0;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 20'h99999;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D], l[LFSR_W-1:1]};
    endfunction

    // Each output byte is a single key bit XOR lfsr bit, replicated eight times.
    function automatic logic [63:0] mask_word(input logic [7:0] k, input logic [7:0] l);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < 8; b++) begin
            w[8*b +: 8] = {8{k[b] ^ l[b]}};
        end
        return w;
    endfunction

endpackage

// File: rtl/mask_lfsr20.sv
// 20-bit Fibonacci LFSR with synchronous reseed; holds its value unless
// load_seed or step is asserted.
module mask_lfsr20
    import lfsr_mask_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_seed,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_seed) begin
            q_d = seed;
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_mask_scheduler.sv
// Round-robin scheduler sharing one LFSR masking datapath among N_REQ
// key sources; emits one masked 64-bit load word per grant.
module lfsr_mask_scheduler
    import lfsr_mask_pkg::*;
#(
    parameter int                N_REQ       = 4,
    parameter int                WARM_CYCLES = 4,
    parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [128*N_REQ-1:0]       key,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           ack,
    output logic                       busy,
    output logic                       load_valid,
    input  logic                       load_ready,
    output logic [63:0]                load,
    output logic [$clog2(N_REQ)-1:0]   load_id
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (WARM_CYCLES > 0) ? $clog2(WARM_CYCLES + 1) : 1;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [7:0]         key_q, key_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               valid_q, valid_d;
    logic [ID_W-1:0]    load_id_q, load_id_d;

    logic               lfsr_load;
    logic               lfsr_step;
    logic [LFSR_W-1:0]  lfsr_q;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;
    logic               unused_bits;

    mask_lfsr20 u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load_seed (lfsr_load),
        .step      (lfsr_step),
        .seed      (SEED),
        .q         (lfsr_q)
    );

    // Scan downward so the last hit written is the first requester at or after rr_q.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_q) + i) % N_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = ID_W'((int'(rr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        warm_cnt_d = warm_cnt_q;
        key_d      = key_q;
        grant_d    = grant_q;
        ack_d      = '0;
        valid_d    = valid_q;
        load_id_d  = load_id_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    key_d     = key[128*int'(pick_idx) +: 8];
                    load_id_d = pick_idx;
                    grant_d   = N_REQ'(1) << pick_idx;
                    state_d   = ST_SEED;
                end
            end
            ST_SEED: begin
                lfsr_load  = 1'b1;
                warm_cnt_d = '0;
                if (WARM_CYCLES > 0) begin
                    state_d = ST_WARM;
                end else begin
                    state_d = ST_EMIT;
                    valid_d = 1'b1;
                end
            end
            ST_WARM: begin
                lfsr_step  = 1'b1;
                warm_cnt_d = warm_cnt_q + 1'b1;
                if (warm_cnt_q == CNT_W'(WARM_CYCLES - 1)) begin
                    state_d = ST_EMIT;
                    valid_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (load_ready) begin
                    ack_d   = N_REQ'(1) << load_id_q;
                    grant_d = '0;
                    valid_d = 1'b0;
                    rr_d    = (load_id_q == ID_W'(N_REQ - 1)) ? '0 : load_id_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            warm_cnt_q <= '0;
            key_q      <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            valid_q    <= 1'b0;
            load_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            warm_cnt_q <= warm_cnt_d;
            key_q      <= key_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            load_id_q  <= load_id_d;
        end
    end

    // Only the low key byte and low LFSR byte reach the mask; fold the rest away.
    always_comb begin
        unused_bits = ^lfsr_q[LFSR_W-1:8];
        for (int r = 0; r < N_REQ; r++) begin
            unused_bits = unused_bits ^ (^key[128*r+8 +: 120]);
        end
    end

    assign grant      = grant_q;
    assign ack        = ack_q;
    assign busy       = (state_q != ST_IDLE);
    assign load_valid = valid_q;
    assign load       = valid_q ? mask_word(key_q, lfsr_q[7:0]) : 64'd0;
    assign load_id    = load_id_q;

endmodule
